rom_download_writer: RTL and testbench
======================================

# rom_download_writer

Bridges the host file-download stream to the SDRAM write port during ROM/BIOS loading. It accepts 16-bit words from the `hps_io` ioctl interface and buffers them in a small FIFO. It issues toggle-handshake write requests to the `sdram` controller and throttles the host with `ioctl_wait`. It holds the emulated core in reset until every buffered word has been acknowledged, and reports word count and checksum for load verification.

## Interface
- `ADDR_W`, 24: SDRAM byte-address width.
- `BASE_ADDR`, 0: byte address of the first word written.
- `FIFO_DEPTH`, 4: buffered words; power of two, ≥2.
- `INDEX_MAX`, 1: highest `ioctl_index[5:0]` treated as ROM/BIOS.

Ports:
- `clk_sys` in 1: single clock. Every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: host download in progress.
- `ioctl_index` in 8: download file index.
- `ioctl_wr` in 1: one-cycle strobe; `ioctl_dout` is valid in the same cycle.
- `ioctl_dout` in 16: data word.
- `ioctl_wait` out 1: host stall request.
- `romwr_a` out ADDR_W: SDRAM write byte address.
- `romwr_d` out 16: SDRAM write data.
- `rom_wr` out 1: write request toggle.
- `sd_wrack` in 1: write acknowledge toggle.
- `core_reset` out 1: holds the emulated core in reset while loading.
- `load_done` out 1: sticky; last load has completed.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.
- `word_count` out ADDR_W-1: number of words acknowledged.
- `checksum` out 16: sum of acknowledged words, modulo 2^16.

## Operation
- `dl_q = ioctl_download & (ioctl_index[5:0] <= INDEX_MAX)`. Its value is registered every cycle to detect rising and falling edges.
- **Rising edge of `dl_q`:**
  - Flush the FIFO.
  - Set `romwr_a` to BASE_ADDR; clear `word_count`, `checksum`, `load_done` and `overflow`.
  - Set `core_reset` to 1.
  - Any `ioctl_wr` arriving in the same cycle is accepted after the flush.
- **Push:** `ioctl_wr & dl_q` and the FIFO is not full → push `ioctl_dout`. If the FIFO is full, drop the word and set `overflow`.
- **`ioctl_wait`** (registered) = `dl_q` & (FIFO occupancy after this edge ≥ FIFO_DEPTH-1). The one remaining slot absorbs a strobe already in flight.
- **Write engine FSM:**
  - RESYNC: wait until `rom_wr == sd_wrack`, then go to IDLE.
  - IDLE: if the FIFO is non-empty, pop the head word, latch it into `romwr_d`, toggle `rom_wr`, and go to WAIT_ACK.
  - WAIT_ACK: when `sd_wrack == rom_wr`:
    - `romwr_a += 2`, wrapping at 2^ADDR_W;
    - `word_count += 1`;
    - `checksum += romwr_d`, modulo 2^16;
    - go to IDLE.
  - `romwr_a` and `romwr_d` stay stable from the toggle until the acknowledge.
- **Falling edge of `dl_q`:** enter drain. The engine continues until the FIFO is empty and the FSM is in IDLE. In the following cycle, `load_done` is set to 1 and `core_reset` to 0.
- **Re-start during drain:** a new rising edge flushes only words not yet popped. An in-flight request still completes, but its acknowledge updates nothing.

## Timing
- **Reset values:**
  - `ioctl_wait`, `core_reset`, `load_done`, `overflow` = 0.
  - `romwr_a` = BASE_ADDR; `word_count` = 0; `checksum` = 0; `romwr_d` = 0.
  - `rom_wr` keeps its value; the FSM enters RESYNC, so an outstanding SDRAM write completes before any new request.
- **Request latency:** a word pushed at edge N, with the engine idle and the FIFO previously empty, toggles `rom_wr` at edge N+1.
- **Acknowledge to next request:** an acknowledge seen at edge M updates the counters at M. The next toggle occurs at edge M+1 at the earliest. Throughput is one word per (SDRAM ack latency + 2) cycles.
- **`ioctl_wait` timing:** rises at the edge where occupancy reaches FIFO_DEPTH-1. It falls at the edge after a pop that lowers occupancy below that level.
- **Done timing:** `load_done` and the `core_reset` deassertion occur exactly 1 cycle after the final acknowledge, or after the falling edge if the FIFO was already drained.
- **Simultaneous push and pop:** occupancy is unchanged.
- **Reset mid-load:** discards the FIFO contents and abandons the download state.

## Test plan
- Single word 0xA55A, SDRAM acks 3 cycles after the toggle:
  - `romwr_a` = 0 and `romwr_d` = 0xA55A at the toggle;
  - `word_count` = 1 and `checksum` = 0xA55A;
  - `load_done` = 1 one cycle after the ack following the download falling edge.
- Burst of 8 back-to-back `ioctl_wr`, words 0x0001..0x0008, ack latency 10:
  - `ioctl_wait` = 1 once 3 words are buffered, and it throttles the host;
  - no `overflow`;
  - final `romwr_a` = 0x10, `word_count` = 8, `checksum` = 0x0024.
- Host ignores `ioctl_wait` and writes 6 words while the SDRAM is stalled:
  - `overflow` = 1 and `word_count` = 5 (4 buffered, 1 in flight);
  - `core_reset` stays high until the drain completes.
- Download with `ioctl_index` = 2: no pushes, `rom_wr` unchanged, `core_reset` stays 0.
- Assert `reset` while in WAIT_ACK:
  - `rom_wr` unchanged and no new toggle until `sd_wrack` matches;
  - counters = 0 afterwards;
  - a new download then starts at BASE_ADDR.
- Checksum wrap: words 0xFFFF and 0x0002 → `checksum` = 0x0001.

Source files
------------

// File: rtl/rom_download_writer.sv
// ROM/BIOS download bridge: buffers ioctl words and writes them to SDRAM
// through the toggle handshake, holding the core in reset until drained.
module rom_download_writer #(
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                INDEX_MAX  = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] romwr_a,
    output logic [15:0]       romwr_d,
    output logic              rom_wr,
    input  logic              sd_wrack,
    output logic              core_reset,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W-2:0] word_count,
    output logic [15:0]       checksum
);

    localparam int             PW       = $clog2(FIFO_DEPTH);
    localparam logic [5:0]     IDX_MAX  = 6'(INDEX_MAX);
    localparam logic [PW:0]    ONE      = (PW+1)'(1);
    localparam logic [PW:0]    FULL_LVL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]    WAIT_LVL = (PW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {RESYNC, IDLE, WAIT_ACK} state_t;

    state_t        state, state_n;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wp;
    logic [PW:0]   count, cnt_n;
    logic          dl_q, dl_r, rise, fall;
    logic          full, empty, push, drop, pop, acked;
    logic          drain, stale, in_flight;
    logic          unused_idx;

    assign unused_idx = ^ioctl_index[7:6];
    assign dl_q  = ioctl_download & (ioctl_index[5:0] <= IDX_MAX);
    assign rise  = dl_q & ~dl_r;
    assign fall  = ~dl_q & dl_r;
    assign full  = (count == FULL_LVL);
    assign empty = (count == '0);
    assign push  = ioctl_wr & dl_q & (rise | ~full);
    assign drop  = ioctl_wr & dl_q & ~rise & full;
    assign wp    = rise ? '0 : wr_ptr;
    // A request already issued when a new load starts must not touch its counters
    assign in_flight = (state == WAIT_ACK) & ~acked;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        acked   = 1'b0;
        unique case (state)
            RESYNC:   if (rom_wr == sd_wrack) state_n = IDLE;
            IDLE: begin
                if (!empty && !rise) begin
                    pop     = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sd_wrack == rom_wr) begin
                    acked   = 1'b1;
                    state_n = IDLE;
                end
            end
            default:  state_n = RESYNC;
        endcase
    end

    always_comb begin
        cnt_n = count;
        if (rise)
            cnt_n = '0;
        else if (pop)
            cnt_n = cnt_n - ONE;
        if (push)
            cnt_n = cnt_n + ONE;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= RESYNC;
        else
            state <= state_n;
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wp] <= ioctl_dout;
    end

    // The request toggle survives reset so an outstanding write can finish
    always_ff @(posedge clk_sys) begin
        if (!reset && pop)
            rom_wr <= ~rom_wr;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wp + 1'b1 : wp;
            count  <= cnt_n;
            if (rise)
                rd_ptr <= '0;
            else if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_r       <= 1'b0;
            ioctl_wait <= 1'b0;
            core_reset <= 1'b0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            drain      <= 1'b0;
            stale      <= 1'b0;
            romwr_a    <= BASE_ADDR;
            romwr_d    <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            dl_r       <= dl_q;
            ioctl_wait <= dl_q & (cnt_n >= WAIT_LVL);
            if (drop)
                overflow <= 1'b1;
            if (pop)
                romwr_d <= mem[rd_ptr];
            if (acked) begin
                if (stale) begin
                    stale   <= 1'b0;
                    romwr_a <= BASE_ADDR;
                end else begin
                    romwr_a    <= romwr_a + ADDR_W'(2);
                    word_count <= word_count + 1'b1;
                    checksum   <= checksum + romwr_d;
                end
            end
            if (rise) begin
                if (in_flight)
                    stale <= 1'b1;
                else
                    romwr_a <= BASE_ADDR;
                word_count <= '0;
                checksum   <= '0;
                load_done  <= 1'b0;
                overflow   <= 1'b0;
                core_reset <= 1'b1;
                drain      <= 1'b0;
            end else if (fall) begin
                drain <= 1'b1;
            end else if (drain && empty && state == IDLE) begin
                drain      <= 1'b0;
                load_done  <= 1'b1;
                core_reset <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_download_writer.sv
// Directed bench for rom_download_writer with a toggle-ack SDRAM model.
module tb_rom_download_writer;

    localparam int AW = 24;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_wr = 1'b0;
    logic [15:0]   ioctl_dout = 16'd0;
    logic          ioctl_wait;
    logic [AW-1:0] romwr_a;
    logic [15:0]   romwr_d;
    logic          rom_wr;
    logic          sd_wrack = 1'b0;
    logic          core_reset;
    logic          load_done;
    logic          overflow;
    logic [AW-2:0] word_count;
    logic [15:0]   checksum;

    int checks = 0;
    int fails = 0;
    int ack_lat = 3;
    bit sd_stall = 1'b0;
    int ack_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    rom_download_writer #(
        .ADDR_W(AW), .BASE_ADDR('0), .FIFO_DEPTH(4), .INDEX_MAX(1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .romwr_a(romwr_a), .romwr_d(romwr_d),
        .rom_wr(rom_wr), .sd_wrack(sd_wrack), .core_reset(core_reset),
        .load_done(load_done), .overflow(overflow),
        .word_count(word_count), .checksum(checksum)
    );

    // SDRAM model: acknowledges ack_lat edges after it sees the toggle
    always @(posedge clk_sys) begin
        if (rom_wr !== sd_wrack && !sd_stall) begin
            if (ack_cnt + 1 >= ack_lat) begin
                sd_wrack <= rom_wr;
                ack_cnt  <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!load_done && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done_timeout: load_done=%0b required 1", name, load_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({ioctl_wait, core_reset, load_done, overflow} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000",
                     {ioctl_wait, core_reset, load_done, overflow});
        end
        checks++;
        if (romwr_a !== 24'h0 || romwr_d !== 16'h0) begin
            fails++;
            $display("FAIL reset_addr_data: a=%h d=%h required 0 0", romwr_a, romwr_d);
        end
        checks++;
        if (word_count !== 23'd0 || checksum !== 16'h0) begin
            fails++;
            $display("FAIL reset_counters: wc=%0d cs=%h required 0 0", word_count, checksum);
        end
    endtask

    task automatic test_single();
        logic r0;
        int n = 0;
        ack_lat = 3;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_dout = 16'hA55A;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        checks++;
        if (core_reset !== 1'b1) begin
            fails++;
            $display("FAIL single_core_reset: got %b required 1", core_reset);
        end
        r0 = rom_wr;
        tick();
        checks++;
        if (rom_wr === r0 || romwr_a !== 24'h0 || romwr_d !== 16'hA55A) begin
            fails++;
            $display("FAIL single_request: rom_wr=%b(was %b) a=%h d=%h required toggled 0 a55a",
                     rom_wr, r0, romwr_a, romwr_d);
        end
        while (word_count == 23'd0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (word_count !== 23'd1 || checksum !== 16'hA55A || load_done !== 1'b0) begin
            fails++;
            $display("FAIL single_ack: wc=%0d cs=%h done=%b required 1 a55a 0",
                     word_count, checksum, load_done);
        end
        tick();
        checks++;
        if (load_done !== 1'b1 || core_reset !== 1'b0) begin
            fails++;
            $display("FAIL single_done: done=%b core_reset=%b required 1 0",
                     load_done, core_reset);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int guard = 0;
        bit seen = 1'b0;
        ack_lat = 10;
        ioctl_download = 1'b1;
        while (sent < 8 && guard < 400) begin
            if (ioctl_wait && !seen) begin
                seen = 1'b1;
                checks++;
                if (sent != 4) begin
                    fails++;
                    $display("FAIL burst_wait_level: words sent=%0d required 4", sent);
                end
            end
            if (!ioctl_wait) begin
                ioctl_wr = 1'b1;
                ioctl_dout = 16'(sent + 1);
                sent++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            guard++;
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL burst_wait_seen: ioctl_wait never 1, required 1");
        end
        wait_done("burst");
        checks++;
        if (romwr_a !== 24'h10 || word_count !== 23'd8 || checksum !== 16'h0024) begin
            fails++;
            $display("FAIL burst_totals: a=%h wc=%0d cs=%h required 10 8 0024",
                     romwr_a, word_count, checksum);
        end
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL burst_overflow: got %b required 0", overflow);
        end
    endtask

    task automatic test_overflow();
        bit bad = 1'b0;
        int n = 0;
        sd_stall = 1'b1;
        ack_lat = 2;
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr = 1'b1;
            ioctl_dout = 16'h0100 + 16'(i);
            tick();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL ovf_flags: ovf=%b core_reset=%b done=%b required 1 1 0",
                     overflow, core_reset, load_done);
        end
        sd_stall = 1'b0;
        while (!load_done && n < 300) begin
            if (core_reset !== 1'b1) bad = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (bad || load_done !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drain: early_release=%b done=%b required 0 1", bad, load_done);
        end
        checks++;
        if (word_count !== 23'd5 || checksum !== 16'h050A || romwr_a !== 24'hA) begin
            fails++;
            $display("FAIL ovf_totals: wc=%0d cs=%h a=%h required 5 050a a",
                     word_count, checksum, romwr_a);
        end
    endtask

    task automatic test_other_index();
        logic r0;
        r0 = rom_wr;
        ioctl_index = 8'd2;
        ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ioctl_wr = 1'b1;
            ioctl_dout = 16'h7700 + 16'(i);
            tick();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        tick();
        tick();
        tick();
        checks++;
        if (rom_wr !== r0 || core_reset !== 1'b0 || word_count !== 23'd5) begin
            fails++;
            $display("FAIL index2: rom_wr=%b(was %b) core_reset=%b wc=%0d required same 0 5",
                     rom_wr, r0, core_reset, word_count);
        end
    endtask

    task automatic test_reset_inflight();
        logic r1;
        int n = 0;
        sd_stall = 1'b1;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_dout = 16'h1234;
        tick();
        ioctl_dout = 16'h5678;
        tick();
        ioctl_wr = 1'b0;
        r1 = rom_wr;
        tick();
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (rom_wr !== r1) begin
            fails++;
            $display("FAIL rst_rom_wr: got %b required %b", rom_wr, r1);
        end
        checks++;
        if (word_count !== 23'd0 || checksum !== 16'h0 || romwr_a !== 24'h0 ||
            overflow !== 1'b0 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_counters: wc=%0d cs=%h a=%h ovf=%b done=%b required all 0",
                     word_count, checksum, romwr_a, overflow, load_done);
        end
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_dout = 16'h00AA;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (rom_wr !== r1) begin
            fails++;
            $display("FAIL rst_resync_hold: rom_wr=%b required %b", rom_wr, r1);
        end
        sd_stall = 1'b0;
        ack_lat = 2;
        while (rom_wr === r1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (rom_wr === r1 || romwr_a !== 24'h0 || romwr_d !== 16'h00AA) begin
            fails++;
            $display("FAIL rst_new_request: rom_wr=%b a=%h d=%h required toggled 0 00aa",
                     rom_wr, romwr_a, romwr_d);
        end
        wait_done("rst");
        checks++;
        if (word_count !== 23'd1 || checksum !== 16'h00AA) begin
            fails++;
            $display("FAIL rst_totals: wc=%0d cs=%h required 1 00aa", word_count, checksum);
        end
    endtask

    task automatic test_checksum_wrap();
        ack_lat = 1;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_dout = 16'hFFFF;
        tick();
        ioctl_dout = 16'h0002;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        wait_done("wrap");
        checks++;
        if (checksum !== 16'h0001 || word_count !== 23'd2 || romwr_a !== 24'h4) begin
            fails++;
            $display("FAIL wrap_totals: cs=%h wc=%0d a=%h required 0001 2 4",
                     checksum, word_count, romwr_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_other_index();
        test_reset_inflight();
        test_checksum_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
